// File: rtl/bram_pipe.sv
`default_nettype none
// ============================================================================
// Module   : bram_pipe
// Purpose  : Byte-masked block RAM with write-first forwarding and a
//            valid/consume handshake on read data. Optional macro
//            BRAM_PIPE_OUTREG_EN adds a second output stage (latency 2).
// Revision : 1.0
// ============================================================================
module bram_pipe #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 1024,
    localparam int c_AW  = $clog2(DEPTH),
    localparam int c_NB  = WIDTH / 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             write__ENA,
    input  logic [c_AW-1:0]  i_write_addr,
    input  logic [WIDTH-1:0] i_write_data,
    input  logic [c_NB-1:0]  i_write_mask,
    output logic             write__RDY,
    input  logic             read__ENA,
    input  logic [c_AW-1:0]  i_read_addr,
    output logic             read__RDY,
    output logic [WIDTH-1:0] dataOut,
    output logic             dataOut__RDY,
    input  logic             dataOut__ENA
);

    localparam logic [c_AW:0] c_DEPTH = (c_AW + 1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             r_armed;
    logic             r_out_valid;
    logic [WIDTH-1:0] r_data_out;

    logic             w_wr_in_range;
    logic             w_rd_in_range;
    logic             w_wr_en;
    logic             w_rd_acc;
    logic [WIDTH-1:0] w_rd_word;

    // Addresses past the end of a non-power-of-two array are decoded, not wrapped.
    assign w_wr_in_range = ({1'b0, i_write_addr} < c_DEPTH);
    assign w_rd_in_range = ({1'b0, i_read_addr} < c_DEPTH);
    assign w_wr_en       = write__ENA & r_armed & ~RST & w_wr_in_range;
    assign w_rd_acc      = read__ENA & read__RDY;

    assign write__RDY    = r_armed;
    assign dataOut       = r_data_out;
    assign dataOut__RDY  = r_out_valid;

    always_comb begin
        w_rd_word = '0;
        if (w_rd_in_range) begin
            w_rd_word = r_mem[i_read_addr];
        end
        for (int i = 0; i < c_NB; i++) begin
            if (w_wr_en && (i_write_addr == i_read_addr) && i_write_mask[i]) begin
                w_rd_word[8*i +: 8] = i_write_data[8*i +: 8];
            end
        end
    end

    // Storage is never reset so contents survive RST.
    always_ff @(posedge CLK) begin
        for (int i = 0; i < c_NB; i++) begin
            if (w_wr_en && i_write_mask[i]) begin
                r_mem[i_write_addr][8*i +: 8] <= i_write_data[8*i +: 8];
            end
        end
    end

`ifdef BRAM_PIPE_OUTREG_EN
    logic             r_s1_valid;
    logic [WIDTH-1:0] r_s1_data;
    logic             w_s1_adv;

    assign w_s1_adv  = r_s1_valid & (~r_out_valid | dataOut__ENA);
    assign read__RDY = r_armed & (~r_s1_valid | w_s1_adv);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_armed     <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_data   <= '0;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
        end else begin
            r_armed <= 1'b1;
            if (w_rd_acc) begin
                r_s1_valid <= 1'b1;
                r_s1_data  <= w_rd_word;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
            if (w_s1_adv) begin
                r_out_valid <= 1'b1;
                r_data_out  <= r_s1_data;
            end else if (dataOut__ENA) begin
                r_out_valid <= 1'b0;
            end
        end
    end
`else
    assign read__RDY = r_armed & (~r_out_valid | dataOut__ENA);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_armed     <= 1'b0;
            r_out_valid <= 1'b0;
            r_data_out  <= '0;
        end else begin
            r_armed <= 1'b1;
            if (w_rd_acc) begin
                r_out_valid <= 1'b1;
                r_data_out  <= w_rd_word;
            end else if (dataOut__ENA) begin
                r_out_valid <= 1'b0;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_bram_pipe.sv
`default_nettype none
// Testbench for bram_pipe (depth 100): table of write/read vectors checked
// through an expected-data queue, plus hand sequences for stall and reset.
module tb_bram_pipe;

    localparam int W = 32;
    localparam int D = 100;
    localparam int AW = 7;
`ifdef BRAM_PIPE_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          wr_ena = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [W-1:0]  wr_data = '0;
    logic [3:0]    wr_mask = '0;
    logic          write__RDY;
    logic          rd_ena = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          read__RDY;
    logic [W-1:0]  dataOut;
    logic          dataOut__RDY;
    logic          dout_ena = 1'b0;

    bram_pipe #(.WIDTH(W), .DEPTH(D)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .write__ENA  (wr_ena),
        .i_write_addr(wr_addr),
        .i_write_data(wr_data),
        .i_write_mask(wr_mask),
        .write__RDY  (write__RDY),
        .read__ENA   (rd_ena),
        .i_read_addr (rd_addr),
        .read__RDY   (read__RDY),
        .dataOut     (dataOut),
        .dataOut__RDY(dataOut__RDY),
        .dataOut__ENA(dout_ena)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit            we;
        logic [AW-1:0] waddr;
        logic [W-1:0]  wdata;
        logic [3:0]    wmask;
        bit            re;
        logic [AW-1:0] raddr;
        logic [W-1:0]  exp;
    } vec_t;

    vec_t         vecs[18];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] pend = '0;
    int           n_checks = 0;
    int           n_errors = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: pop on consume, push the pending expectation on accept.
    task automatic monitor();
        if (RST) begin
            exp_q.delete();
        end else begin
            if (dataOut__RDY && dout_ena) begin
                if (exp_q.size() == 0) chk("dataOut__RDY_spurious", 32'(dataOut__RDY), 32'd0);
                else                   chk("dataOut", dataOut, exp_q.pop_front());
            end
            if (rd_ena) begin
                chk("read__RDY_accept", 32'(read__RDY), 32'd1);
                if (read__RDY) exp_q.push_back(pend);
            end
        end
    endtask

    task automatic step();
        @(negedge CLK);
        monitor();
        @(posedge CLK);
        #1;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [W-1:0] e);
        rd_ena  = 1'b1;
        rd_addr = a;
        pend    = e;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [3:0] m);
        wr_ena  = 1'b1;
        wr_addr = a;
        wr_data = d;
        wr_mask = m;
    endtask

    initial begin
        vecs[0]  = '{1, 7'd5,   32'hAABBCCDD, 4'hF, 0, 7'd0,   32'h0};
        vecs[1]  = '{1, 7'd5,   32'h11223344, 4'h5, 0, 7'd0,   32'h0};
        vecs[2]  = '{0, 7'd0,   32'h0,        4'h0, 1, 7'd5,   32'hAA22CC44};
        vecs[3]  = '{1, 7'd9,   32'h00000000, 4'hF, 0, 7'd0,   32'h0};
        vecs[4]  = '{1, 7'd9,   32'hDEADBEEF, 4'h3, 1, 7'd9,   32'h0000BEEF};
        vecs[5]  = '{1, 7'd1,   32'h00000001, 4'hF, 0, 7'd0,   32'h0};
        vecs[6]  = '{1, 7'd2,   32'h00000002, 4'hF, 0, 7'd0,   32'h0};
        vecs[7]  = '{1, 7'd20,  32'h12345678, 4'hF, 0, 7'd0,   32'h0};
        vecs[8]  = '{1, 7'd120, 32'hFFFFFFFF, 4'hF, 0, 7'd0,   32'h0};
        vecs[9]  = '{0, 7'd0,   32'h0,        4'h0, 1, 7'd120, 32'h0};
        vecs[10] = '{0, 7'd0,   32'h0,        4'h0, 1, 7'd20,  32'h12345678};
        vecs[11] = '{1, 7'd30,  32'hCAFEF00D, 4'hF, 0, 7'd0,   32'h0};
        vecs[12] = '{1, 7'd30,  32'hFFFFFFFF, 4'h0, 1, 7'd30,  32'hCAFEF00D};
        vecs[13] = '{1, 7'd9,   32'hA5A5A5A5, 4'hC, 1, 7'd9,   32'hA5A5BEEF};
        vecs[14] = '{0, 7'd0,   32'h0,        4'h0, 1, 7'd1,   32'h00000001};
        vecs[15] = '{0, 7'd0,   32'h0,        4'h0, 1, 7'd2,   32'h00000002};
        vecs[16] = '{0, 7'd0,   32'h0,        4'h0, 1, 7'd5,   32'hAA22CC44};
        vecs[17] = '{1, 7'd9,   32'h00000000, 4'h1, 1, 7'd1,   32'h00000001};

        // Reset and arming.
        @(posedge CLK); #1;
        repeat (3) step();
        chk("rst_dataOut", dataOut, 32'h0);
        chk("rst_dataOut__RDY", 32'(dataOut__RDY), 32'd0);
        chk("rst_write__RDY", 32'(write__RDY), 32'd0);
        chk("rst_read__RDY", 32'(read__RDY), 32'd0);
        RST = 1'b0;
        #1;
        chk("release_write__RDY", 32'(write__RDY), 32'd0);
        chk("release_read__RDY", 32'(read__RDY), 32'd0);
        chk("release_dataOut__RDY", 32'(dataOut__RDY), 32'd0);
        step();
        chk("armed_write__RDY", 32'(write__RDY), 32'd1);
        chk("armed_read__RDY", 32'(read__RDY), 32'd1);
        chk("armed_dataOut", dataOut, 32'h0);
        chk("armed_dataOut__RDY", 32'(dataOut__RDY), 32'd0);

        // Vector table, consumer always ready.
        dout_ena = 1'b1;
        for (int i = 0; i < 18; i++) begin
            wr_ena  = vecs[i].we;
            wr_addr = vecs[i].waddr;
            wr_data = vecs[i].wdata;
            wr_mask = vecs[i].wmask;
            rd_ena  = vecs[i].re;
            rd_addr = vecs[i].raddr;
            pend    = vecs[i].exp;
            step();
        end
        wr_ena = 1'b0;
        rd_ena = 1'b0;
        repeat (LAT + 1) step();
        chk("table_drain", 32'(exp_q.size()), 32'd0);

        // Backpressure: hold addr 1 for four cycles.
        dout_ena = 1'b0;
        rd(7'd1, 32'h1);
        step();
        rd_ena = 1'b0;
        repeat (LAT - 1) step();
        for (int k = 0; k < 4; k++) begin
            chk("stall_dataOut", dataOut, 32'h1);
            chk("stall_dataOut__RDY", 32'(dataOut__RDY), 32'd1);
`ifndef BRAM_PIPE_OUTREG_EN
            chk("stall_read__RDY", 32'(read__RDY), 32'd0);
`endif
            step();
        end
        dout_ena = 1'b1;
        rd(7'd2, 32'h2);
        #1;
        chk("unstall_read__RDY", 32'(read__RDY), 32'd1);
        step();
        rd_ena = 1'b0;
        repeat (LAT) step();
        chk("held_dataOut", dataOut, 32'h2);
        chk("drained_dataOut__RDY", 32'(dataOut__RDY), 32'd0);
        chk("bp_drain", 32'(exp_q.size()), 32'd0);

        // Reset mid-read; writes in reset and before arming must be dropped.
        dout_ena = 1'b0;
        rd(7'd5, 32'hAA22CC44);
`ifdef BRAM_PIPE_OUTREG_EN
        step();
        rd_ena = 1'b0;
`endif
        RST = 1'b1;
        wr(7'd30, 32'h0, 4'hF);
        step();
        rd_ena = 1'b0;
        wr_ena = 1'b0;
        chk("rstmid_dataOut__RDY_a", 32'(dataOut__RDY), 32'd0);
        step();
        chk("rstmid_dataOut__RDY_b", 32'(dataOut__RDY), 32'd0);
        RST = 1'b0;
        wr(7'd1, 32'h00000BAD, 4'hF);
        step();
        wr_ena = 1'b0;
        chk("rstmid_dataOut__RDY_c", 32'(dataOut__RDY), 32'd0);
        dout_ena = 1'b1;
        rd(7'd5, 32'hAA22CC44);
        step();
        rd(7'd30, 32'hCAFEF00D);
        step();
        rd(7'd1, 32'h00000001);
        step();
        rd_ena = 1'b0;
        repeat (LAT + 1) step();
        chk("rstmid_drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
